// File: rtl/vdp_cpu_port_if.sv
// VRAM access bus between the VDP CPU port and the shared VRAM arbiter.
// The requester holds req/we/addr/wdata stable until a one-cycle ack;
// read data is valid together with ack.
interface vdp_cpu_port_if #(
    parameter int ADDR_W = 14
);
    logic              vram_req;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_wdata;
    logic              vram_ack;
    logic [7:0]        vram_rdata;

    modport master (
        output vram_req,
        output vram_we,
        output vram_addr,
        output vram_wdata,
        input  vram_ack,
        input  vram_rdata
    );

    modport slave (
        input  vram_req,
        input  vram_we,
        input  vram_addr,
        input  vram_wdata,
        output vram_ack,
        output vram_rdata
    );
endinterface

// File: rtl/vdp_cpu_port.sv
// TMS9918-style CPU-side port of the VDP: data port (0x98) and control
// port (0x99) decode, register file, VRAM address pointer, two-byte
// control latch, read-ahead buffer, status register and frame interrupt.
// Optional build macro: VDP_SPRITE_STATUS_EN adds the sprite collision /
// fifth-sprite status inputs; without it C, 5S and fifth read as 0.
module vdp_cpu_port #(
    parameter int ADDR_W   = 14,
    parameter int NUM_REGS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  io_wr,
    input  logic                  io_rd,
    input  logic                  port_sel,
    input  logic [7:0]            cpu_din,
    output logic [7:0]            cpu_dout,
    vdp_cpu_port_if.master        vram,
    input  logic                  frame_end,
`ifdef VDP_SPRITE_STATUS_EN
    input  logic                  coll_set,
    input  logic                  fifth_set,
    input  logic [4:0]            fifth_num,
`endif
    output logic [8*NUM_REGS-1:0] vdp_regs,
    output logic                  n_int,
    output logic                  overrun
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR_PEND = 2'd1;
    localparam logic [1:0] ST_RD_PEND = 2'd2;

    // Register index is masked to the register count (power of two).
    localparam logic [2:0] REG_MASK = 3'(NUM_REGS - 1);

    logic [1:0]        state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              flag_r;
    logic [7:0]        first_r;
    logic [7:0]        rahead_r;
    logic [7:0]        regs_r [NUM_REGS];
    logic              req_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        wdata_r;
    logic              n_int_r;
    logic              overrun_r;
    logic              f_r;
    logic              s5_r;
    logic              c_r;
    logic [4:0]        fifth_r;

    logic              data_wr_s;
    logic              data_rd_s;
    logic              ctrl_wr_s;
    logic              ctrl_rd_s;
    logic              idle_s;
    logic              ctrl_second_s;
    logic              rd_setup_s;
    logic              ptr_load_s;
    logic              reg_wr_s;
    logic              start_wr_s;
    logic              start_rd_s;
    logic              drop_s;
    logic              ack_s;
    logic [ADDR_W-1:0] setup_ptr_s;
    logic [2:0]        reg_idx_s;
    logic [7:0]        status_s;

    // Access decode and handshake qualification.
    always_comb begin
        data_wr_s     = io_wr & ~port_sel;
        data_rd_s     = io_rd & ~port_sel & ~io_wr;
        ctrl_wr_s     = io_wr & port_sel;
        ctrl_rd_s     = io_rd & port_sel & ~io_wr;
        idle_s        = (state_r == ST_IDLE);
        ctrl_second_s = ctrl_wr_s & flag_r;
        rd_setup_s    = ctrl_second_s & (cpu_din[7:6] == 2'b00);
        ptr_load_s    = ctrl_second_s & ~cpu_din[7];
        reg_wr_s      = ctrl_second_s & cpu_din[7];
        start_wr_s    = data_wr_s & idle_s;
        start_rd_s    = (data_rd_s | rd_setup_s) & idle_s;
        drop_s        = (data_wr_s | data_rd_s | rd_setup_s) & ~idle_s;
        // An ack seen while idle belongs to nobody and is ignored.
        ack_s         = vram.vram_ack & ~idle_s;
        setup_ptr_s   = ADDR_W'({cpu_din[5:0], first_r});
        reg_idx_s     = cpu_din[2:0] & REG_MASK;
        status_s      = {f_r, s5_r, c_r, fifth_r};
    end

    // CPU read mux: status on the control port, read-ahead on the data port.
    always_comb begin
        cpu_dout = 8'h00;
        if (ctrl_rd_s) begin
            cpu_dout = status_s;
        end else if (data_rd_s) begin
            cpu_dout = rahead_r;
        end else begin
            cpu_dout = 8'h00;
        end
    end

    // Access sequencer: launches one VRAM access and holds it until ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 8'h00;
        end else begin
            if (start_wr_s) begin
                state_r <= ST_WR_PEND;
                req_r   <= 1'b1;
                we_r    <= 1'b1;
                addr_r  <= ptr_r;
                wdata_r <= cpu_din;
            end else if (start_rd_s) begin
                state_r <= ST_RD_PEND;
                req_r   <= 1'b1;
                we_r    <= 1'b0;
                // A read setup fetches from the pointer it is loading.
                addr_r  <= rd_setup_s ? setup_ptr_s : ptr_r;
            end else if (ack_s) begin
                state_r <= ST_IDLE;
                req_r   <= 1'b0;
            end else begin
                state_r <= state_r;
                req_r   <= req_r;
            end
        end
    end

    // Address pointer: loaded by a pointer setup, advanced on each completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= '0;
        end else if (ptr_load_s) begin
            // An explicit CPU load wins over a coincident auto-increment.
            ptr_r <= setup_ptr_s;
        end else if (ack_s) begin
            ptr_r <= ptr_r + ADDR_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Read-ahead buffer captures data of each completed read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rahead_r <= 8'h00;
        end else if (ack_s && (state_r == ST_RD_PEND)) begin
            rahead_r <= vram.vram_rdata;
        end else begin
            rahead_r <= rahead_r;
        end
    end

    // Two-byte control latch; any data access or status read resynchronises it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_r  <= 1'b0;
            first_r <= 8'h00;
        end else if (data_wr_s || data_rd_s || ctrl_rd_s) begin
            flag_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            if (flag_r) begin
                flag_r <= 1'b0;
            end else begin
                flag_r  <= 1'b1;
                first_r <= cpu_din;
            end
        end else begin
            flag_r <= flag_r;
        end
    end

    // VDP register file written by the second control byte with bit 7 set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (reg_wr_s) begin
            regs_r[reg_idx_s] <= first_r;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Frame flag: set by frame_end, cleared by a status read (set wins).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_r <= 1'b0;
        end else if (frame_end) begin
            f_r <= 1'b1;
        end else if (ctrl_rd_s) begin
            f_r <= 1'b0;
        end else begin
            f_r <= f_r;
        end
    end

`ifdef VDP_SPRITE_STATUS_EN
    // Sprite status: collision and first fifth-sprite event (set wins).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_r     <= 1'b0;
            s5_r    <= 1'b0;
            fifth_r <= 5'd0;
        end else begin
            if (coll_set) begin
                c_r <= 1'b1;
            end else if (ctrl_rd_s) begin
                c_r <= 1'b0;
            end else begin
                c_r <= c_r;
            end
            if (fifth_set && !s5_r) begin
                s5_r    <= 1'b1;
                fifth_r <= fifth_num;
            end else if (ctrl_rd_s) begin
                s5_r <= 1'b0;
            end else begin
                s5_r <= s5_r;
            end
        end
    end
`else
    assign c_r     = 1'b0;
    assign s5_r    = 1'b0;
    assign fifth_r = 5'd0;
`endif

    // Sticky overrun and registered interrupt output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_r <= 1'b0;
            n_int_r   <= 1'b1;
        end else begin
            overrun_r <= overrun_r | drop_s;
            n_int_r   <= ~(f_r & regs_r[1][5]);
        end
    end

    // Flatten the register file onto the output bus.
    always_comb begin
        vdp_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            vdp_regs[8*i +: 8] = regs_r[i];
        end
    end

    assign vram.vram_req   = req_r;
    assign vram.vram_we    = we_r;
    assign vram.vram_addr  = addr_r;
    assign vram.vram_wdata = wdata_r;
    assign n_int           = n_int_r;
    assign overrun         = overrun_r;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed self-checking bench for vdp_cpu_port with a VRAM arbiter model
// that acknowledges every request three cycles after it appears.
module tb_vdp_cpu_port;

    logic        cpuClock;
    logic        reset_n;
    logic        io_wr;
    logic        io_rd;
    logic        port_sel;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        frame_end;
    logic [63:0] vdp_regs;
    logic        n_int;
    logic        overrun;
`ifdef VDP_SPRITE_STATUS_EN
    logic        coll_set;
    logic        fifth_set;
    logic [4:0]  fifth_num;
`endif

    int n_checks;
    int n_fail;

    logic [7:0]  mem [0:16383];
    logic [13:0] log_addr  [$];
    logic        log_we    [$];
    logic [7:0]  log_wdata [$];

    vdp_cpu_port_if #(.ADDR_W(14)) vif ();

    vdp_cpu_port #(.ADDR_W(14), .NUM_REGS(8)) dut (
        .clk       (cpuClock),
        .reset_n   (reset_n),
        .io_wr     (io_wr),
        .io_rd     (io_rd),
        .port_sel  (port_sel),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .vram      (vif),
        .frame_end (frame_end),
`ifdef VDP_SPRITE_STATUS_EN
        .coll_set  (coll_set),
        .fifth_set (fifth_set),
        .fifth_num (fifth_num),
`endif
        .vdp_regs  (vdp_regs),
        .n_int     (n_int),
        .overrun   (overrun)
    );

    initial cpuClock = 1'b0;
    always #5 cpuClock = ~cpuClock;

    // VRAM arbiter model: log each request, ack it three cycles later.
    initial begin
        vif.vram_ack   = 1'b0;
        vif.vram_rdata = 8'h00;
        forever begin
            @(posedge cpuClock);
            #1;
            if (vif.vram_req) begin
                log_addr.push_back(vif.vram_addr);
                log_we.push_back(vif.vram_we);
                log_wdata.push_back(vif.vram_wdata);
                repeat (2) @(posedge cpuClock);
                #1;
                vif.vram_ack = 1'b1;
                if (vif.vram_we) begin
                    mem[vif.vram_addr] = vif.vram_wdata;
                    vif.vram_rdata = 8'h00;
                end else begin
                    vif.vram_rdata = mem[vif.vram_addr];
                end
                @(posedge cpuClock);
                #1;
                vif.vram_ack = 1'b0;
            end
        end
    end

    // All CPU tasks start and end 1 time unit after a rising edge.
    task automatic io_write(input logic sel, input logic [7:0] d);
        io_wr    = 1'b1;
        port_sel = sel;
        cpu_din  = d;
        @(posedge cpuClock);
        #1;
        io_wr = 1'b0;
    endtask

    task automatic io_read(input logic sel, output logic [7:0] d);
        io_rd    = 1'b1;
        port_sel = sel;
        #1;
        d = cpu_dout;
        @(posedge cpuClock);
        #1;
        io_rd = 1'b0;
    endtask

    task automatic wait_req_low();
        for (int i = 0; i < 20 && vif.vram_req; i++) begin
            @(posedge cpuClock);
            #1;
        end
        n_checks++;
        if (vif.vram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL req_timeout: vram_req=%b required 0 within 20 cycles", vif.vram_req);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        n_checks++;
        if (vif.vram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b required 0", vif.vram_req); end
        n_checks++;
        if (n_int !== 1'b1) begin n_fail++; $display("FAIL reset_nint: got %b required 1", n_int); end
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b required 0", overrun); end
        n_checks++;
        if (vdp_regs !== 64'h0) begin n_fail++; $display("FAIL reset_regs: got %h required 0", vdp_regs); end
        io_read(1'b1, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h required 00", d); end
    endtask

    task automatic test_reg_write();
        logic [7:0] d;
        int base;
        io_write(1'b1, 8'hE0);
        io_write(1'b1, 8'h81);
        n_checks++;
        if (vdp_regs !== 64'h0000_0000_0000_E000) begin n_fail++; $display("FAIL regwr_regs: got %h required e000", vdp_regs); end
        n_checks++;
        if (vif.vram_req !== 1'b0) begin n_fail++; $display("FAIL regwr_noreq: got %b required 0", vif.vram_req); end
        // Pointer must still be 0: a data read fetches from 0x0000.
        base = log_addr.size();
        io_read(1'b0, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL regwr_rahead: got %h required 00", d); end
        wait_req_low();
        n_checks++;
        if (log_addr.size() != base + 1 || log_addr[base] !== 14'h0000 || log_we[base] !== 1'b0) begin
            n_fail++; $display("FAIL regwr_ptr: %0d new requests, addr %h required one read at 0000", log_addr.size() - base, log_addr[base]);
        end
    endtask

    task automatic test_write_burst();
        logic [7:0] d;
        int base;
        base = log_addr.size();
        io_write(1'b1, 8'h00);
        io_write(1'b1, 8'h40);
        io_write(1'b0, 8'h11);
        wait_req_low();
        io_write(1'b0, 8'h22);
        wait_req_low();
        io_read(1'b0, d);
        wait_req_low();
        n_checks++;
        if (log_addr.size() != base + 3) begin
            n_fail++; $display("FAIL burst_count: got %0d requests required 3", log_addr.size() - base);
        end else begin
            n_checks++;
            if (log_addr[base] !== 14'h0000 || log_we[base] !== 1'b1 || log_wdata[base] !== 8'h11) begin
                n_fail++; $display("FAIL burst_w0: got addr %h we %b data %h required 0000 1 11", log_addr[base], log_we[base], log_wdata[base]);
            end
            n_checks++;
            if (log_addr[base+1] !== 14'h0001 || log_we[base+1] !== 1'b1 || log_wdata[base+1] !== 8'h22) begin
                n_fail++; $display("FAIL burst_w1: got addr %h we %b data %h required 0001 1 22", log_addr[base+1], log_we[base+1], log_wdata[base+1]);
            end
            n_checks++;
            if (log_addr[base+2] !== 14'h0002 || log_we[base+2] !== 1'b0) begin
                n_fail++; $display("FAIL burst_ptr: got addr %h we %b required 0002 0", log_addr[base+2], log_we[base+2]);
            end
        end
    endtask

    task automatic test_read_ahead();
        logic [7:0] d;
        int base;
        mem[14'h3FFF] = 8'hAB;
        mem[14'h0000] = 8'hCD;
        base = log_addr.size();
        io_write(1'b1, 8'hFF);
        io_write(1'b1, 8'h3F);
        wait_req_low();
        io_read(1'b0, d);
        n_checks++;
        if (d !== 8'hAB) begin n_fail++; $display("FAIL ra_first: got %h required ab", d); end
        wait_req_low();
        io_read(1'b0, d);
        n_checks++;
        if (d !== 8'hCD) begin n_fail++; $display("FAIL ra_second: got %h required cd", d); end
        wait_req_low();
        n_checks++;
        if (log_addr.size() != base + 3) begin
            n_fail++; $display("FAIL ra_count: got %0d requests required 3", log_addr.size() - base);
        end else begin
            n_checks++;
            if (log_addr[base] !== 14'h3FFF) begin n_fail++; $display("FAIL ra_setup_addr: got %h required 3fff", log_addr[base]); end
            n_checks++;
            if (log_addr[base+1] !== 14'h0000) begin n_fail++; $display("FAIL ra_wrap_addr: got %h required 0000", log_addr[base+1]); end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        int base;
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_before: got %b required 0", overrun); end
        base = log_addr.size();
        io_write(1'b0, 8'h55);
        io_write(1'b0, 8'h66);
        wait_req_low();
        repeat (6) @(posedge cpuClock);
        #1;
        n_checks++;
        if (log_addr.size() != base + 1 || log_wdata[base] !== 8'h55) begin
            n_fail++; $display("FAIL ovr_single: got %0d requests data %h required 1 with 55", log_addr.size() - base, log_wdata[base]);
        end
        n_checks++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b required 1", overrun); end
        io_read(1'b1, d);
        repeat (3) @(posedge cpuClock);
        #1;
        n_checks++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b required 1", overrun); end
    endtask

    task automatic test_interrupt();
        logic [7:0] d;
        io_write(1'b1, 8'h20);
        io_write(1'b1, 8'h81);
        n_checks++;
        if (vdp_regs !== 64'h0000_0000_0000_2000) begin n_fail++; $display("FAIL irq_reg1: got %h required 2000", vdp_regs); end
        frame_end = 1'b1;
        @(posedge cpuClock);
        #1;
        frame_end = 1'b0;
        n_checks++;
        if (n_int !== 1'b1) begin n_fail++; $display("FAIL irq_delay: got %b required 1", n_int); end
        @(posedge cpuClock);
        #1;
        n_checks++;
        if (n_int !== 1'b0) begin n_fail++; $display("FAIL irq_assert: got %b required 0", n_int); end
        io_read(1'b1, d);
        n_checks++;
        if (d !== 8'h80) begin n_fail++; $display("FAIL irq_status: got %h required 80", d); end
        @(posedge cpuClock);
        #1;
        n_checks++;
        if (n_int !== 1'b1) begin n_fail++; $display("FAIL irq_release: got %b required 1", n_int); end
        frame_end = 1'b1;
        io_read(1'b1, d);
        frame_end = 1'b0;
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL irq_coinc_read: got %h required 00", d); end
        io_read(1'b1, d);
        n_checks++;
        if (d !== 8'h80) begin n_fail++; $display("FAIL irq_set_wins: got %h required 80", d); end
        io_read(1'b1, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL irq_cleared: got %h required 00", d); end
    endtask

    task automatic test_latch_reset();
        logic [7:0] d;
        int base;
        base = log_addr.size();
        io_write(1'b1, 8'h12);
        io_read(1'b1, d);
        io_write(1'b1, 8'h34);
        io_write(1'b1, 8'h40);
        io_write(1'b0, 8'h77);
        wait_req_low();
        n_checks++;
        if (log_addr.size() != base + 1 || log_addr[base] !== 14'h0034 || log_wdata[base] !== 8'h77) begin
            n_fail++; $display("FAIL latch_ptr: got %0d requests addr %h required one at 0034", log_addr.size() - base, log_addr[base]);
        end
        // Asynchronous reset in the middle of a pending write.
        io_write(1'b0, 8'h99);
        n_checks++;
        if (vif.vram_req !== 1'b1) begin n_fail++; $display("FAIL arst_pending: got %b required 1", vif.vram_req); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (vif.vram_req !== 1'b0) begin n_fail++; $display("FAIL arst_req: got %b required 0", vif.vram_req); end
        n_checks++;
        if (n_int !== 1'b1 || overrun !== 1'b0 || vdp_regs !== 64'h0) begin
            n_fail++; $display("FAIL arst_outputs: n_int %b overrun %b regs %h required 1 0 0", n_int, overrun, vdp_regs);
        end
        repeat (2) @(posedge cpuClock);
        #3;
        reset_n = 1'b1;
        // The arbiter's late ack now lands in idle and must be ignored.
        repeat (5) @(posedge cpuClock);
        #1;
        n_checks++;
        if (vif.vram_req !== 1'b0 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL arst_idle_ack: req %b overrun %b required 0 0", vif.vram_req, overrun);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        io_wr     = 1'b0;
        io_rd     = 1'b0;
        port_sel  = 1'b0;
        cpu_din   = 8'h00;
        frame_end = 1'b0;
`ifdef VDP_SPRITE_STATUS_EN
        coll_set  = 1'b0;
        fifth_set = 1'b0;
        fifth_num = 5'd0;
`endif
        for (int i = 0; i < 16384; i++) begin
            mem[i] = 8'h00;
        end
        repeat (3) @(posedge cpuClock);
        #3;
        reset_n = 1'b1;
        @(posedge cpuClock);
        #1;
        test_reset();
        test_reg_write();
        test_write_burst();
        test_read_ahead();
        test_overrun();
        test_interrupt();
        test_latch_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
